// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module   : game_timer
// Purpose  : Countdown game timer. Loads the per-level time budget, counts it
//            down in whole seconds (prescaled system clock) and raises the
//            level signal timer_stop when the budget is exhausted. The
//            remaining time is driven both in binary and as three BCD digits.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            load, timer_seconds - start a countdown from timer_seconds
//            halt                - freeze the value (game won/lost)
//            pause               - level, suspends counting while high
//            clear               - zero everything, back to idle
//            timer_stop          - high while the budget is exhausted
//            running             - high in the RUN state only
//            sec_tick            - one-cycle pulse on every decrement
//            seconds_left        - remaining seconds, binary
//            bcd_hund/tens/ones  - remaining seconds, decimal digits
// Revision : 1.0 - initial release
// ============================================================================
module game_timer #(
    parameter int CLK_FREQ_HZ = 40_000_000,
    parameter int SEC_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEC_W-1:0] timer_seconds,
    input  logic             halt,
    input  logic             pause,
    input  logic             clear,
    output logic             timer_stop,
    output logic             running,
    output logic             sec_tick,
    output logic [SEC_W-1:0] seconds_left,
    output logic [3:0]       bcd_hund,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
);

    localparam int              c_PW      = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(CLK_FREQ_HZ - 1);
    localparam logic [SEC_W-1:0] c_SEC_MAX = SEC_W'(999);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RUN     = 3'd1;
    localparam logic [2:0] c_PAUSED  = 3'd2;
    localparam logic [2:0] c_HELD    = 3'd3;
    localparam logic [2:0] c_EXPIRED = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [c_PW-1:0]  r_presc;
    logic [c_PW-1:0]  w_presc_next;
    logic [SEC_W-1:0] r_sec;
    logic [SEC_W-1:0] w_sec_next;
    logic [11:0]      r_bcd;
    logic [11:0]      w_bcd_next;
    logic             r_tick;
    logic             w_tick_next;
    logic             r_stop;
    logic             r_running;

    logic [SEC_W-1:0] w_load_val;
    logic [11:0]      w_load_bcd;
    logic             w_active;
    logic             w_wrap;

    // Shift-and-add-3 conversion of the loaded value; only used on load, the
    // countdown itself keeps the digits in step with a ripple-borrow decrement.
    // Hundreds never reaches 5 because the value is clamped to 999.
    function automatic logic [11:0] to_bcd(input logic [SEC_W-1:0] v);
        logic [11:0] b;
        b = 12'd0;
        for (int i = SEC_W - 1; i >= 0; i--) begin
            if (b[3:0] >= 4'd5) b[3:0] = b[3:0] + 4'd3;
            if (b[7:4] >= 4'd5) b[7:4] = b[7:4] + 4'd3;
            b = {b[10:0], v[i]};
        end
        return b;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        if (b[3:0] != 4'd0) begin
            r[3:0] = b[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (b[7:4] != 4'd0) begin
                r[7:4] = b[7:4] - 4'd1;
            end else begin
                r[7:4]  = 4'd9;
                r[11:8] = b[11:8] - 4'd1;
            end
        end
        return r;
    endfunction

    assign w_load_val = (32'(timer_seconds) > 32'd999) ? c_SEC_MAX : timer_seconds;
    assign w_load_bcd = to_bcd(w_load_val);
    assign w_active   = (r_state == c_RUN) || (r_state == c_PAUSED);
    assign w_wrap     = (r_presc == c_PRE_MAX);

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_presc   <= '0;
            r_sec     <= '0;
            r_bcd     <= 12'd0;
            r_tick    <= 1'b0;
            r_stop    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_presc   <= w_presc_next;
            r_sec     <= w_sec_next;
            r_bcd     <= w_bcd_next;
            r_tick    <= w_tick_next;
            r_stop    <= (w_state_next == c_EXPIRED);
            r_running <= (w_state_next == c_RUN);
        end
    end

    // Next-state logic. Releasing pause counts on the same edge, so a paused
    // interval delays the countdown by exactly the cycles pause was high.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = c_IDLE;
        end else if (load) begin
            w_state_next = (w_load_val != '0) ? c_RUN : c_EXPIRED;
        end else if (halt && w_active) begin
            w_state_next = c_HELD;
        end else if (w_active) begin
            if (pause)
                w_state_next = c_PAUSED;
            else if (w_wrap && (r_sec == SEC_W'(1)))
                w_state_next = c_EXPIRED;
            else
                w_state_next = c_RUN;
        end
    end

    // Datapath / output logic
    always_comb begin
        w_presc_next = r_presc;
        w_sec_next   = r_sec;
        w_bcd_next   = r_bcd;
        w_tick_next  = 1'b0;
        if (clear) begin
            w_presc_next = '0;
            w_sec_next   = '0;
            w_bcd_next   = 12'd0;
        end else if (load) begin
            w_presc_next = '0;
            w_sec_next   = w_load_val;
            w_bcd_next   = w_load_bcd;
        end else if (halt && w_active) begin
            w_presc_next = r_presc;
        end else if (w_active && !pause) begin
            if (w_wrap) begin
                w_presc_next = '0;
                if (r_sec != '0) begin
                    w_sec_next  = r_sec - SEC_W'(1);
                    w_bcd_next  = bcd_dec(r_bcd);
                    w_tick_next = 1'b1;
                end
            end else begin
                w_presc_next = r_presc + c_PW'(1);
            end
        end
    end

    assign timer_stop   = r_stop;
    assign running      = r_running;
    assign sec_tick     = r_tick;
    assign seconds_left = r_sec;
    assign bcd_hund     = r_bcd[11:8];
    assign bcd_tens     = r_bcd[7:4];
    assign bcd_ones     = r_bcd[3:0];

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_timer
// Purpose  : Self-checking bench for game_timer with a behavioural model that
//            tracks mode, seconds and prescaler position as plain integers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_timer;

    localparam int F = 4;
    localparam int W = 10;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_HELD = 3, M_EXP = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] timer_seconds = '0;
    logic         halt = 1'b0;
    logic         pause = 1'b0;
    logic         clear = 1'b0;
    logic         timer_stop, running, sec_tick;
    logic [W-1:0] seconds_left;
    logic [3:0]   bcd_hund, bcd_tens, bcd_ones;

    int vectors = 0;
    int miscompares = 0;

    int m_mode = M_IDLE;
    int m_sec  = 0;
    int m_pre  = 0;
    bit m_tick = 1'b0;

    game_timer #(.CLK_FREQ_HZ(F), .SEC_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .timer_seconds(timer_seconds),
        .halt(halt), .pause(pause), .clear(clear), .timer_stop(timer_stop),
        .running(running), .sec_tick(sec_tick), .seconds_left(seconds_left),
        .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = M_IDLE; m_sec = 0; m_pre = 0; m_tick = 1'b0;
    endfunction

    // One clock edge of the behavioural rules with the inputs present at it.
    function automatic void model_edge();
        int lv;
        bit act;
        m_tick = 1'b0;
        act = (m_mode == M_RUN) || (m_mode == M_PAUSED);
        if (clear) begin
            model_reset();
        end else if (load) begin
            lv = (int'(timer_seconds) > 999) ? 999 : int'(timer_seconds);
            m_sec = lv; m_pre = 0;
            m_mode = (lv > 0) ? M_RUN : M_EXP;
        end else if (halt && act) begin
            m_mode = M_HELD;
        end else if (act && pause) begin
            m_mode = M_PAUSED;
        end else if (act) begin
            m_mode = M_RUN;
            m_pre = m_pre + 1;
            if (m_pre == F) begin
                m_pre = 0;
                m_sec = m_sec - 1;
                m_tick = 1'b1;
                if (m_sec == 0) m_mode = M_EXP;
            end
        end
    endfunction

    function automatic logic [24:0] exp_vec();
        return {m_mode == M_EXP, m_mode == M_RUN, m_tick, W'(m_sec),
                4'(m_sec / 100), 4'((m_sec / 10) % 10), 4'(m_sec % 10)};
    endfunction

    function automatic logic [24:0] obs_vec();
        return {timer_stop, running, sec_tick, seconds_left, bcd_hund, bcd_tens, bcd_ones};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (obs_vec() !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_state got=%h want=0", obs_vec());
        end
        rst_n = 1'b1;
        model_reset();
        repeat (5) begin
            step();
            vectors++;
            if (obs_vec() !== 25'd0) begin
                miscompares++;
                $display("FAIL reset_idle got=%h want=0", obs_vec());
            end
        end
    endtask

    task automatic test_count3();
        timer_seconds = W'(3); load = 1'b1; step(); load = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            vectors++;
            if (sec_tick !== ((k % 4 == 0) && (k <= 12))) begin
                miscompares++;
                $display("FAIL count3_tick k=%0d got=%b", k, sec_tick);
            end
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL count3_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if ({timer_stop, running, seconds_left} !== {1'b1, 1'b0, W'(0)}) begin
            miscompares++;
            $display("FAIL count3_end stop=%b run=%b sec=%0d want 1/0/0", timer_stop, running, seconds_left);
        end
    endtask

    task automatic test_bcd();
        timer_seconds = W'(100); load = 1'b1; step(); load = 1'b0;
        repeat (F) step();
        vectors++;
        if ({seconds_left, bcd_hund, bcd_tens, bcd_ones} !== {W'(99), 4'd0, 4'd9, 4'd9}) begin
            miscompares++;
            $display("FAIL bcd_borrow got=%0d %0d/%0d/%0d want=99 0/9/9", seconds_left, bcd_hund, bcd_tens, bcd_ones);
        end
        timer_seconds = W'(1000); load = 1'b1; step(); load = 1'b0;
        vectors++;
        if ({seconds_left, bcd_hund, bcd_tens, bcd_ones} !== {W'(999), 4'd9, 4'd9, 4'd9}) begin
            miscompares++;
            $display("FAIL bcd_clamp got=%0d %0d/%0d/%0d want=999 9/9/9", seconds_left, bcd_hund, bcd_tens, bcd_ones);
        end
    endtask

    task automatic test_pause();
        int gap;
        timer_seconds = W'(5); load = 1'b1; step(); load = 1'b0;
        repeat (2) step();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            vectors++;
            if (sec_tick !== 1'b0 || seconds_left !== W'(5) || running !== 1'b0) begin
                miscompares++;
                $display("FAIL pause_hold k=%0d tick=%b sec=%0d run=%b", k, sec_tick, seconds_left, running);
            end
        end
        pause = 1'b0;
        gap = -1;
        for (int k = 1; k <= 8 && gap < 0; k++) begin
            step();
            if (sec_tick === 1'b1) gap = k;
        end
        vectors++;
        if (gap != 2) begin
            miscompares++;
            $display("FAIL pause_resume gap=%0d want=2", gap);
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL pause_model got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_halt();
        // halt on the same edge as a prescaler wrap: no decrement
        timer_seconds = W'(5); load = 1'b1; step(); load = 1'b0;
        repeat (F - 1) step();
        halt = 1'b1; step(); halt = 1'b0;
        vectors++;
        if ({sec_tick, seconds_left, running} !== {1'b0, W'(5), 1'b0}) begin
            miscompares++;
            $display("FAIL halt_wrap tick=%b sec=%0d run=%b want 0/5/0", sec_tick, seconds_left, running);
        end
        timer_seconds = W'(5); load = 1'b1; step(); load = 1'b0;
        repeat (2 * F) step();
        halt = 1'b1; step(); halt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            vectors++;
            if ({timer_stop, sec_tick, seconds_left} !== {1'b0, 1'b0, W'(3)} || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL halt_hold k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
        end
        clear = 1'b1; step(); clear = 1'b0;
        vectors++;
        if (obs_vec() !== 25'd0) begin
            miscompares++;
            $display("FAIL halt_clear got=%h want=0", obs_vec());
        end
    endtask

    task automatic test_load0();
        timer_seconds = W'(0); load = 1'b1; step(); load = 1'b0;
        repeat (2) begin
            vectors++;
            if ({timer_stop, running, sec_tick, seconds_left} !== {1'b1, 1'b0, 1'b0, W'(0)}) begin
                miscompares++;
                $display("FAIL load0 stop=%b run=%b tick=%b sec=%0d", timer_stop, running, sec_tick, seconds_left);
            end
            repeat (F) step();
        end
    endtask

    task automatic test_clear_load();
        timer_seconds = W'(9); load = 1'b1; step();
        repeat (2) step();
        clear = 1'b1; step(); clear = 1'b0; load = 1'b0;
        for (int k = 0; k < 2 * F; k++) begin
            vectors++;
            if (obs_vec() !== 25'd0) begin
                miscompares++;
                $display("FAIL clear_load k=%0d got=%h want=0", k, obs_vec());
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        timer_seconds = W'(9); load = 1'b1; step(); load = 1'b0;
        repeat (F + 2) step();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs_vec() !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_async got=%h want=0", obs_vec());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3 * F; k++) begin
            step();
            vectors++;
            if (obs_vec() !== 25'd0) begin
                miscompares++;
                $display("FAIL reset_release k=%0d got=%h want=0", k, obs_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            load  = ($urandom_range(0, 29) == 0);
            timer_seconds = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 1023))
                                                        : W'($urandom_range(0, 6));
            halt  = ($urandom_range(0, 39) == 0);
            clear = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
        end
        load = 1'b0; halt = 1'b0; clear = 1'b0; pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count3();
        test_bcd();
        test_pause();
        test_halt();
        test_load0();
        test_clear_load();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_timer.md
# game_timer

Countdown game timer feeding `main_fsm`. It loads the per-level time budget when a game starts and counts it down in whole seconds, deriving each second by prescaling the system clock. On expiry it raises the level signal `timer_stop`, which `main_fsm` consumes to end the game. It also drives the remaining time as binary and as three BCD digits for the display path.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 40_000_000: clock cycles per counted second. Benches override it with a small value.
- `SEC_W`, default 10: width of the seconds value. The supported maximum is 999.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `load`, input, 1: single-cycle pulse. Starts a countdown from `timer_seconds`.
- `timer_seconds`, input, SEC_W: time budget from game setup. Sampled only on `load`.
- `halt`, input, 1: single-cycle pulse on game won or lost. Freezes the current value.
- `pause`, input, 1: level. While high, the countdown is suspended.
- `clear`, input, 1: single-cycle pulse on return to menu. Zeroes the value and returns to idle.
- `timer_stop`, output, 1: high while the time budget is exhausted.
- `running`, output, 1: high in RUN state only.
- `sec_tick`, output, 1: one-cycle pulse on every decrement.
- `seconds_left`, output, SEC_W: remaining seconds in binary.
- `bcd_hund`, output, 4: hundreds digit of `seconds_left`.
- `bcd_tens`, output, 4: tens digit of `seconds_left`.
- `bcd_ones`, output, 4: ones digit of `seconds_left`.

## Operation
States:
- IDLE: reset state.
- RUN: counting down.
- PAUSED: counting suspended.
- HELD: value frozen after the game ends.
- EXPIRED: budget exhausted.

Command priority, evaluated each cycle from highest to lowest: `clear`, `load`, `halt`, `pause`, prescaler tick.

Commands:
- `clear` in any state: go to IDLE. Zero `seconds_left`, all BCD digits and the prescaler. Deassert `timer_stop`.
- `load` in any state:
  - Set `seconds_left` to min(`timer_seconds`, 999) and load the BCD digits to match.
  - Zero the prescaler and deassert `timer_stop`.
  - If the loaded value is greater than 0, go to RUN. If it is 0, go to EXPIRED and assert `timer_stop`.
- `halt` in RUN or PAUSED: go to HELD. `seconds_left` is frozen. `halt` in IDLE, HELD or EXPIRED is ignored.
- `pause` high in RUN: go to PAUSED. The prescaler holds its value.
- `pause` low in PAUSED: return to RUN. The prescaler resumes from the value it held, so no partial second is lost.

Counting in RUN:
- The prescaler counts 0..CLK_FREQ_HZ-1 and wraps to 0.
- On each wrap:
  - Decrement `seconds_left` by 1.
  - Update the BCD digits incrementally, with ripple borrow: ones 0→9 borrows from tens, tens 0→9 borrows from hundreds.
  - Pulse `sec_tick`.
- When the decrement takes the value from 1 to 0, go to EXPIRED.

EXPIRED:
- `timer_stop` is high and stays high until `clear` or `load`.
- `seconds_left` stays at 0. It never wraps below 0.

Invariants:
- The BCD digits always equal the decimal form of `seconds_left`. The implementation must not use a combinational divider.
- `running` equals (state == RUN).

## Timing
- All outputs are registered.
- Reset values: state IDLE; `timer_stop`, `running`, `sec_tick` = 0; `seconds_left`, all BCD digits and the prescaler = 0.
- `load` at rising edge N:
  - `seconds_left` and the BCD digits take the loaded value after edge N.
  - `running` goes high after edge N.
  - The first `sec_tick` occurs CLK_FREQ_HZ cycles later, visible after edge N+CLK_FREQ_HZ.
- `sec_tick`, the new `seconds_left` and the new BCD digits update in the same cycle.
- On the final decrement, `timer_stop` rises in the same cycle that `seconds_left` becomes 0, together with `sec_tick`.
- `halt`, `pause` and `clear` take effect at the next edge. If `halt` and a prescaler wrap fall on the same edge, `halt` wins and no decrement occurs.
- `load` and `clear` on the same edge: `clear` wins.
- Reset asserted mid-count: all outputs return to their reset values immediately (asynchronous). After `rst_n` is released, the block stays in IDLE until a `load`.

## Test plan
All scenarios use CLK_FREQ_HZ=4.
- Load 3, no other inputs:
  - `sec_tick` at cycles 4, 8 and 12 after load; `seconds_left` goes 3→2→1→0.
  - `timer_stop` rises with the third tick. `running` = 0 afterwards.
- Load 100:
  - After one tick: `seconds_left` = 99 and BCD digits = 0/9/9.
  - Load 1000: `seconds_left` = 999.
- Load 5, then `pause` for 10 cycles at prescaler = 2:
  - No tick while paused.
  - After release, the next tick arrives 2 cycles later.
- Load 5, then `halt` after 2 ticks:
  - `seconds_left` holds 3 indefinitely; `timer_stop` stays 0.
  - `clear`: all outputs go to 0.
- Load 0: the next cycle shows `timer_stop` = 1 and state EXPIRED.
- Load 9, then `clear` and `load` on the same edge: the block is in IDLE with `seconds_left` = 0.
- Load 9, then pull `rst_n` low mid-second: outputs go to 0 asynchronously, and no tick follows after release.
